// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: request/grant/select bundle between two requesters and the mux2 arbiter.
interface mux_arbiter_if;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;
    modport master (output req0, req1, input gnt0, gnt1, sel, busy);
    modport slave (input req0, req1, output gnt0, gnt1, sel, busy);
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester arbiter for a shared mux2 path with bounded hold and fair tie-break.
module mux_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [3:0] LIM = 4'(HOLD_MAX - 1);
    state_t     r_state;
    state_t     w_nxt;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_sel;
    logic       r_busy;
    logic       w_stay0;
    logic       w_stay1;
    always_comb begin
        w_stay0 = (r_state == OWN0) && bus.req0 && (!bus.req1 || r_cnt < LIM);
        w_stay1 = (r_state == OWN1) && bus.req1 && (!bus.req0 || r_cnt < LIM);
        // Ties from IDLE go to whoever did not own the path last.
        w_nxt = w_stay0 ? OWN0 :
                w_stay1 ? OWN1 :
                (r_state == OWN0) ? (bus.req1 ? OWN1 : IDLE) :
                (r_state == OWN1) ? (bus.req0 ? OWN0 : IDLE) :
                (bus.req0 && (!bus.req1 || r_last)) ? OWN0 :
                bus.req1 ? OWN1 : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (w_nxt == r_state && w_nxt != IDLE) ? ((r_cnt == LIM) ? r_cnt : r_cnt + 4'd1) : 4'd0;
            r_last  <= (w_nxt == OWN1) ? 1'b1 : (w_nxt == OWN0) ? 1'b0 : r_last;
            r_gnt0  <= w_nxt == OWN0;
            r_gnt1  <= w_nxt == OWN1;
            r_sel   <= (w_nxt == OWN1) ? 1'b1 : (w_nxt == OWN0) ? 1'b0 : r_sel;
            r_busy  <= w_nxt != IDLE;
        end
    end
    assign bus.gnt0 = r_gnt0;
    assign bus.gnt1 = r_gnt1;
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scoreboard bench for mux_arbiter with HOLD_MAX=4 and HOLD_MAX=1 instances.
module tb_mux_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];
    logic [3:0] got;
    logic [3:0] exp_v;
    // Expected output words are {gnt0, gnt1, sel, busy}.
    localparam logic [3:0] O0 = 4'b1001;
    localparam logic [3:0] O1 = 4'b0111;
    localparam logic [3:0] I0 = 4'b0000;
    localparam logic [3:0] I1 = 4'b0010;
    mux_arbiter_if bus0 ();
    mux_arbiter_if bus1 ();
    mux_arbiter #(.HOLD_MAX(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    mux_arbiter #(.HOLD_MAX(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    always #5 clk = ~clk;
    task automatic set_req(input logic a, input logic b);
        @(negedge clk);
        bus0.req0 = a;
        bus0.req1 = b;
    endtask
    task automatic test_reset();
        bus0.req0 = 1'b0;
        bus0.req1 = 1'b0;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        #2;
        sb.push_back(I0);
        got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_async got=%b exp=%b", got, exp_v); end
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(I0);
        got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_held got=%b exp=%b", got, exp_v); end
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_alternate();
        set_req(1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            sb.push_back(((k / 4) % 2 == 0) ? O0 : O1);
            @(posedge clk);
            #1;
            got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL alternate k=%0d got=%b exp=%b", k, got, exp_v); end
            checks++;
            if (bus0.gnt0 && bus0.gnt1) begin errors++; $display("FAIL both_grants k=%0d got=11 exp=not 11", k); end
        end
        set_req(1'b0, 1'b0);
        sb.push_back(I1);
        @(posedge clk);
        #1;
        got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL alternate_idle got=%b exp=%b", got, exp_v); end
    endtask
    task automatic test_pulse1();
        logic [3:0] seq [3] = '{O1, I1, I1};
        for (int k = 0; k < 3; k++) begin
            set_req(1'b0, k == 0);
            sb.push_back(seq[k]);
            @(posedge clk);
            #1;
            got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL pulse1 k=%0d got=%b exp=%b", k, got, exp_v); end
        end
    endtask
    task automatic test_handoff();
        logic [1:0] rq  [8] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [3:0] seq [8] = '{O0, O0, O1, O1, O1, O1, O0, I0};
        for (int k = 0; k < 8; k++) begin
            set_req(rq[k][1], rq[k][0]);
            sb.push_back(seq[k]);
            @(posedge clk);
            #1;
            got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL handoff k=%0d got=%b exp=%b", k, got, exp_v); end
        end
    endtask
    task automatic test_lone();
        set_req(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            sb.push_back(O0);
            @(posedge clk);
            #1;
            got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL lone k=%0d got=%b exp=%b", k, got, exp_v); end
        end
        set_req(1'b0, 1'b0);
        @(posedge clk);
    endtask
    task automatic test_async_reset();
        set_req(1'b0, 1'b1);
        sb.push_back(O1);
        @(posedge clk);
        #1;
        got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL areset_own1 got=%b exp=%b", got, exp_v); end
        #1;
        rst = 1'b1;
        #1;
        sb.push_back(I0);
        got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL areset_drop got=%b exp=%b", got, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        bus0.req0 = 1'b1;
        bus0.req1 = 1'b1;
        sb.push_back(O0);
        @(posedge clk);
        #1;
        got = {bus0.gnt0, bus0.gnt1, bus0.sel, bus0.busy};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL areset_first got=%b exp=%b", got, exp_v); end
        set_req(1'b0, 1'b0);
        @(posedge clk);
    endtask
    task automatic test_hold1();
        @(negedge clk);
        bus1.req0 = 1'b1;
        bus1.req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb.push_back((k % 2 == 0) ? O0 : O1);
            @(posedge clk);
            #1;
            got = {bus1.gnt0, bus1.gnt1, bus1.sel, bus1.busy};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL hold1 k=%0d got=%b exp=%b", k, got, exp_v); end
        end
        @(negedge clk);
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
    endtask
    initial begin
        test_reset();
        test_alternate();
        test_pulse1();
        test_handoff();
        test_lone();
        test_async_reset();
        test_hold1();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
